// File: rtl/ice51_pkg.sv
// Shared ice51 constants and the UART receive state encoding.
// The top level, the loader and the UART TX all import this package.
package ice51_pkg;
  localparam int CLKS_PER_BIT_DEF = 104;
  localparam int MEM_SIZE_DEF     = 512;
  localparam int ADDR_W_DEF       = 9;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;
endpackage

// File: rtl/ice51_uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchroniser and mid-bit sampling.
// It emits a one-cycle byte strobe, or a one-cycle frame-error pulse when the stop bit is low.
module ice51_uart_rx
  import ice51_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       rx_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          armed_q, armed_d;
  logic          vld_q, vld_d;
  logic          ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      armed_q <= 1'b1;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      armed_q <= armed_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  // armed blocks a new start until the line has been seen high, so a line
  // stuck low after a framing error cannot generate a stream of bytes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    armed_d = armed_q | rx_s;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s && armed_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            vld_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_vld_o  = vld_q;
  assign byte_o      = sh_q;
  assign frame_err_o = ferr_q;
endmodule

// File: rtl/ice51_uart_loader.sv
// UART boot loader: writes MEM_SIZE received bytes to code memory from address 0,
// holding the core in reset until the last byte is written.
module ice51_uart_loader
  import ice51_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int MEM_SIZE     = MEM_SIZE_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int PRELOAD      = 0
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_uart_rx,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_cpu_rst,
  output logic              o_done,
  output logic              o_frame_err
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_SIZE - 1);
  localparam logic              PRE  = (PRELOAD != 0);

  logic              byte_vld;
  logic [7:0]        rx_byte;
  logic              rx_ferr;

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              ferr_q, ferr_d;

  ice51_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .rx_i       (i_uart_rx),
    .byte_vld_o (byte_vld),
    .byte_o     (rx_byte),
    .frame_err_o(rx_ferr)
  );

  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= PRE;
      cpu_rst_q <= ~PRE;
      ferr_q    <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      cpu_rst_q <= cpu_rst_d;
      ferr_q    <= ferr_d;
    end
  end

  // Pointer saturates at LAST; the strobe at LAST ends loading on the next cycle.
  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    cpu_rst_d = cpu_rst_q;
    ferr_d    = ferr_q | rx_ferr;
    if (byte_vld && !done_q) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = rx_byte;
      if (ptr_q != LAST) ptr_d = ptr_q + ADDR_W'(1);
    end
    if (wr_en_q && wr_addr_q == LAST) begin
      done_d    = 1'b1;
      cpu_rst_d = 1'b0;
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_cpu_rst   = cpu_rst_q;
  assign o_done      = done_q;
  assign o_frame_err = ferr_q;
endmodule

// File: tb/tb_ice51_uart_loader.sv
// Directed bench for the UART boot loader, scaled to a short bit time and small image.
// A second instance with PRELOAD=1 listens to the same line and must never write.
module tb_ice51_uart_loader;
  localparam int C  = 16;
  localparam int H  = C / 2;
  localparam int M  = 16;
  localparam int AW = 4;
  localparam int LAT = 2 + H + 9 * C + 1;

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic          rx = 1'b1;
  logic          wr_en, cpu_rst, done, ferr;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          p_wr_en, p_cpu_rst, p_done, p_ferr;
  logic [AW-1:0] p_wr_addr;
  logic [7:0]    p_wr_data;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  ice51_uart_loader #(.CLKS_PER_BIT(C), .MEM_SIZE(M), .ADDR_W(AW), .PRELOAD(0)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_uart_rx(rx),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_cpu_rst(cpu_rst), .o_done(done), .o_frame_err(ferr)
  );

  ice51_uart_loader #(.CLKS_PER_BIT(C), .MEM_SIZE(M), .ADDR_W(AW), .PRELOAD(1)) dut_pre (
    .i_clk(clk), .i_nrst(nrst), .i_uart_rx(rx),
    .o_wr_en(p_wr_en), .o_wr_addr(p_wr_addr), .o_wr_data(p_wr_data),
    .o_cpu_rst(p_cpu_rst), .o_done(p_done), .o_frame_err(p_ferr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log and invariants, sampled on the falling edge.
  logic [AW-1:0] wa_q[$];
  logic [7:0]    wd_q[$];
  int            wc_q[$];
  bit            prev_wr = 1'b0, prev_done = 1'b0, consec = 1'b0, rst_bad = 1'b0;
  int            done_cyc = 0;
  int            p_wr = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wc_q.push_back(cyc);
      if (prev_wr) consec = 1'b1;
    end
    prev_wr = wr_en;
    if (done && !prev_done) done_cyc = cyc;
    prev_done = done;
    if (cpu_rst !== ~done) rst_bad = 1'b1;
    if (p_wr_en) p_wr++;
  end

  task automatic do_reset;
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    wa_q.delete(); wd_q.delete(); wc_q.delete();
  endtask

  // Leaves the line at the stop-bit level.
  task automatic send_byte(input logic [7:0] b, input logic stop_v, output int t0);
    @(negedge clk);
    rx = 1'b0;
    t0 = cyc;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop_v;
    repeat (C) @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    nvec++; if (wr_en !== 1'b0) begin nerr++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    nvec++; if (wr_addr !== '0) begin nerr++; $display("FAIL reset_wr_addr got %0h want 0", wr_addr); end
    nvec++; if (wr_data !== 8'h00) begin nerr++; $display("FAIL reset_wr_data got %0h want 0", wr_data); end
    nvec++; if (cpu_rst !== 1'b1) begin nerr++; $display("FAIL reset_cpu_rst got %b want 1", cpu_rst); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done); end
    nvec++; if (ferr !== 1'b0) begin nerr++; $display("FAIL reset_frame_err got %b want 0", ferr); end
    nvec++; if (p_done !== 1'b1) begin nerr++; $display("FAIL preload_reset_done got %b want 1", p_done); end
    nvec++; if (p_cpu_rst !== 1'b0) begin nerr++; $display("FAIL preload_reset_cpu_rst got %b want 0", p_cpu_rst); end
  endtask

  task automatic test_glitch;
    int t0, d;
    do_reset();
    @(negedge clk);
    rx = 1'b0;
    repeat (H / 2) @(negedge clk);
    rx = 1'b1;
    repeat (2 * C) @(negedge clk);
    nvec++; if (wa_q.size() != 0) begin nerr++; $display("FAIL glitch_nowrite got %0d writes want 0", wa_q.size()); end
    send_byte(8'h3C, 1'b1, t0);
    repeat (4) @(negedge clk);
    nvec++;
    if (wa_q.size() != 1) begin
      nerr++; $display("FAIL glitch_count got %0d writes want 1", wa_q.size());
    end else begin
      nvec++; if (wa_q[0] !== 4'd0 || wd_q[0] !== 8'h3C) begin
        nerr++; $display("FAIL glitch_write got addr %0h data %0h want addr 0 data 3c", wa_q[0], wd_q[0]);
      end
      d = wc_q[0] - t0;
      nvec++; if (d < LAT - 2 || d > LAT + 2) begin
        nerr++; $display("FAIL latency got %0d cycles want %0d +-2", d, LAT);
      end
    end
    nvec++; if (ferr !== 1'b0) begin nerr++; $display("FAIL glitch_ferr got %b want 0", ferr); end
  endtask

  task automatic test_frame_err;
    int t0;
    do_reset();
    send_byte(8'h55, 1'b0, t0);
    repeat (3 * C) @(negedge clk);
    nvec++; if (ferr !== 1'b1) begin nerr++; $display("FAIL frame_err_flag got %b want 1", ferr); end
    nvec++; if (wa_q.size() != 0) begin nerr++; $display("FAIL frame_err_nowrite got %0d writes want 0", wa_q.size()); end
    rx = 1'b1;
    repeat (2 * C) @(negedge clk);
    send_byte(8'h81, 1'b1, t0);
    repeat (4) @(negedge clk);
    nvec++;
    if (wa_q.size() != 1) begin
      nerr++; $display("FAIL frame_err_count got %0d writes want 1", wa_q.size());
    end else if (wa_q[0] !== 4'd0 || wd_q[0] !== 8'h81) begin
      nerr++; $display("FAIL frame_err_write got addr %0h data %0h want addr 0 data 81", wa_q[0], wd_q[0]);
    end
    nvec++; if (ferr !== 1'b1) begin nerr++; $display("FAIL frame_err_sticky got %b want 1", ferr); end
  endtask

  task automatic test_full_load;
    int t0;
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < M; i++) send_byte(8'(i * 37 + 5), 1'b1, t0);
    repeat (4) @(negedge clk);
    nvec++;
    if (wa_q.size() != M) begin
      nerr++; $display("FAIL load_count got %0d writes want %0d", wa_q.size(), M);
    end else begin
      for (int i = 0; i < M; i++) begin
        e = 8'(i * 37 + 5);
        nvec++; if (wa_q[i] !== AW'(i) || wd_q[i] !== e) begin
          nerr++; $display("FAIL load_write[%0d] got addr %0h data %0h want addr %0h data %0h", i, wa_q[i], wd_q[i], i, e);
        end
      end
      nvec++; if (done_cyc != wc_q[M-1] + 1) begin
        nerr++; $display("FAIL done_timing got cycle %0d want %0d", done_cyc, wc_q[M-1] + 1);
      end
    end
    nvec++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin
      nerr++; $display("FAIL load_release got done %b cpu_rst %b want 1 0", done, cpu_rst);
    end
  endtask

  task automatic test_extra;
    int t0;
    send_byte(8'hA5, 1'b1, t0);
    repeat (4) @(negedge clk);
    nvec++; if (wa_q.size() != M) begin nerr++; $display("FAIL extra_nowrite got %0d writes want %0d", wa_q.size(), M); end
    nvec++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin
      nerr++; $display("FAIL extra_state got done %b cpu_rst %b want 1 0", done, cpu_rst);
    end
    nvec++; if (wr_addr !== AW'(M - 1) || wr_data !== 8'((M - 1) * 37 + 5)) begin
      nerr++; $display("FAIL extra_hold got addr %0h data %0h want addr %0h data %0h", wr_addr, wr_data, M - 1, 8'((M - 1) * 37 + 5));
    end
  endtask

  task automatic test_reset_mid;
    int t0;
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'(i * 37 + 5), 1'b1, t0);
    @(negedge clk);
    rx = 1'b0;
    repeat (4 * C) @(negedge clk);
    nrst = 1'b1;
    #1;
    nvec++; if (cpu_rst !== 1'b1 || wr_en !== 1'b0) begin
      nerr++; $display("FAIL midreset_async got cpu_rst %b wr_en %b want 1 0", cpu_rst, wr_en);
    end
    repeat (10) @(negedge clk);
    rx = 1'b1;
    nrst = 1'b0;
    repeat (2 * C) @(negedge clk);
    nvec++; if (wa_q.size() != 5) begin nerr++; $display("FAIL midreset_partial got %0d writes want 5", wa_q.size()); end
    for (int i = 0; i < M - 1; i++) send_byte(8'(i * 37 + 5), 1'b1, t0);
    repeat (4) @(negedge clk);
    nvec++; if (done !== 1'b0 || cpu_rst !== 1'b1) begin
      nerr++; $display("FAIL midreset_early got done %b cpu_rst %b want 0 1", done, cpu_rst);
    end
    send_byte(8'((M - 1) * 37 + 5), 1'b1, t0);
    repeat (4) @(negedge clk);
    nvec++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin
      nerr++; $display("FAIL midreset_done got done %b cpu_rst %b want 1 0", done, cpu_rst);
    end
    nvec++;
    if (wa_q.size() != 5 + M) begin
      nerr++; $display("FAIL midreset_count got %0d writes want %0d", wa_q.size(), 5 + M);
    end else if (wa_q[5] !== 4'd0 || wd_q[5] !== 8'd5 || wa_q[5+M-1] !== AW'(M - 1)) begin
      nerr++; $display("FAIL midreset_restart got first addr %0h data %0h last addr %0h want 0 05 %0h", wa_q[5], wd_q[5], wa_q[5+M-1], M - 1);
    end
  endtask

  task automatic test_preload;
    int t0;
    send_byte(8'hFF, 1'b1, t0);
    repeat (4) @(negedge clk);
    nvec++; if (p_wr != 0) begin nerr++; $display("FAIL preload_nowrite got %0d strobes want 0", p_wr); end
    nvec++; if (p_done !== 1'b1 || p_cpu_rst !== 1'b0) begin
      nerr++; $display("FAIL preload_state got done %b cpu_rst %b want 1 0", p_done, p_cpu_rst);
    end
  endtask

  task automatic test_invariants;
    nvec++; if (consec) begin nerr++; $display("FAIL back_to_back_strobe got consecutive o_wr_en want none"); end
    nvec++; if (rst_bad) begin nerr++; $display("FAIL cpu_rst_vs_done got cpu_rst==done at some cycle want complement"); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_frame_err();
    test_full_load();
    test_extra();
    test_reset_mid();
    test_preload();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
